// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the execute-stage controller and the multiply/divide unit.
// The controller uses the master modport; the unit owns HI/LO and drives them back.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Each operation works on operand magnitudes for WIDTH cycles; signs are restored in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_next;

  logic             busy, load, step, commit;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, m_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             neg_res, neg_rem, div_zero;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic             is_signed, is_div;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0] quot, rem, res_hi, res_lo;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy   = 1'b0;
    load   = 1'b0;
    step   = 1'b0;
    commit = 1'b0;
    unique case (state)
      IDLE:    load = bus.start;
      RUN:     begin busy = 1'b1; step = 1'b1; end
      FIX:     begin busy = 1'b1; commit = 1'b1; end
      default: ;
    endcase
  end

  // Operand magnitudes for the signed ops; unsigned ops pass through untouched
  always_comb begin
    is_signed = ~bus.op[0];
    is_div    = bus.op[1];
    abs_a     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // acc upper half is the partial product / remainder, lower half the multiplier / dividend
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m_q} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_q};
    if (div_diff[WIDTH]) div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else                 div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Final sign fix-up and divide-by-zero override
  always_comb begin
    prod   = neg_res ? -acc : acc;
    quot   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_q[1]) begin
      if (div_zero) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      a_q      <= '0;
      m_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= commit;
      if (load) begin
        op_q     <= bus.op;
        a_q      <= bus.a;
        m_q      <= is_div ? abs_b : abs_a;
        acc      <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
        cnt      <= '0;
        neg_res  <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        neg_rem  <= is_signed && bus.a[WIDTH-1];
        div_zero <= is_div && (bus.b == '0);
      end else if (step) begin
        cnt <= cnt + 1'b1;
        acc <= op_q[1] ? div_next : mul_next;
      end
      // MTHI/MTLO only land while idle; an operation result always wins at FIX
      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (!busy) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy;
  assign bus.done = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized bench for muldiv_unit; expected HI/LO come from plain
// 64-bit arithmetic on the original operands.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   elapsed = 0;

  muldiv_unit_if #(.WIDTH(32)) bus();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'd0: res = sa * sb;
      2'd1: res = ua * ub;
      2'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else res = {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
      end
    endcase
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.busy === 1'b1) elapsed++;
  endtask

  // Issue one operation at the current (idle) negedge; operands are scrambled after E0
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    elapsed   = 0;
    tick();
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.a     = $urandom;
    bus.b     = $urandom;
    checkOutput({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
    checkOutput({tag, " done_low_after_start"}, 64'(bus.done), 64'd0);
  endtask

  task automatic waitDone(input string tag, input logic [63:0] exp);
    int guard = 0;
    while (bus.busy === 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    checkOutput({tag, " busy_cycles"}, 64'(elapsed), 64'd33);
    checkOutput({tag, " done"}, 64'(bus.done), 64'd1);
    checkOutput({tag, " hi"}, 64'(bus.hi), 64'(exp[63:32]));
    checkOutput({tag, " lo"}, 64'(bus.lo), 64'(exp[31:0]));
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          doneSeen;

    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    $display("[TB] starting muldiv_unit bench");

    tick();
    tick();
    checkOutput("reset hi", 64'(bus.hi), 64'd0);
    checkOutput("reset lo", 64'(bus.lo), 64'd0);
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset done", 64'(bus.done), 64'd0);
    reset = 1'b0;
    tick();

    // Back-to-back directed ops: each start lands in the previous done cycle
    applyStimulus("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd7);
    waitDone("mult_neg", 64'hFFFFFFFF_FFFFFFEB);
    applyStimulus("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone("multu_max", 64'hFFFFFFFE_00000001);
    applyStimulus("div_neg", 2'd2, 32'hFFFFFFF9, 32'd2);
    waitDone("div_neg", 64'hFFFFFFFF_FFFFFFFD);
    applyStimulus("divu", 2'd3, 32'd100, 32'd7);
    waitDone("divu", 64'h00000002_0000000E);
    applyStimulus("divu_zero", 2'd3, 32'h12345678, 32'd0);
    waitDone("divu_zero", 64'h12345678_FFFFFFFF);
    applyStimulus("div_wrap", 2'd2, 32'h80000000, 32'hFFFFFFFF);
    waitDone("div_wrap", 64'h00000000_80000000);
    tick();
    checkOutput("done_single_cycle", 64'(bus.done), 64'd0);

    // MTHI/MTLO while idle
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h13579BDF;
    tick();
    bus.lo_we = 1'b0;
    bus.wdata = 32'hAAAA5555;
    checkOutput("mt_both hi", 64'(bus.hi), 64'h13579BDF);
    checkOutput("mt_both lo", 64'(bus.lo), 64'h13579BDF);
    tick();
    bus.hi_we = 1'b0;
    checkOutput("mthi hi", 64'(bus.hi), 64'hAAAA5555);
    checkOutput("mthi lo_kept", 64'(bus.lo), 64'h13579BDF);

    // Writes and starts while busy are dropped
    applyStimulus("multu_small", 2'd1, 32'd2, 32'd3);
    tick();
    tick();
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hDEADBEEF;
    bus.start = 1'b1;
    bus.op    = 2'd0;
    tick();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.start = 1'b0;
    checkOutput("busy_write hi_held", 64'(bus.hi), 64'hAAAA5555);
    checkOutput("busy_write lo_held", 64'(bus.lo), 64'h13579BDF);
    waitDone("multu_small", 64'h00000000_00000006);
    tick();
    checkOutput("no_queued_start", 64'(bus.busy), 64'd0);

    // MTHI in the same cycle as an accepted start
    bus.hi_we = 1'b1;
    bus.wdata = 32'hCAFEF00D;
    applyStimulus("start_with_mthi", 2'd3, 32'd100, 32'd7);
    checkOutput("start_with_mthi hi_at_E0", 64'(bus.hi), 64'hCAFEF00D);
    waitDone("start_with_mthi", 64'h00000002_0000000E);
    tick();

    // Reset in the middle of RUN
    applyStimulus("mult_reset", 2'd0, 32'd5, 32'd9);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midreset busy", 64'(bus.busy), 64'd0);
    checkOutput("midreset done", 64'(bus.done), 64'd0);
    checkOutput("midreset hi", 64'(bus.hi), 64'd0);
    checkOutput("midreset lo", 64'(bus.lo), 64'd0);
    doneSeen = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) doneSeen++;
    end
    checkOutput("midreset no_done", 64'(doneSeen), 64'd0);
    applyStimulus("after_reset", 2'd0, 32'hFFFFFFF0, 32'h00001234);
    waitDone("after_reset", refModel(2'd0, 32'hFFFFFFF0, 32'h00001234));
    tick();

    // Randomized ops with bias toward the corner operands
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h80000000;
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      applyStimulus($sformatf("rand%0d", i), rop, ra, rb);
      waitDone($sformatf("rand%0d", i), refModel(rop, ra, rb));
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
